// File: rtl/snl_pkg.sv
// snl_pkg: shared constants, FSM state encoding and die-face helper for the
// snakes-and-ladders turn scheduler.
//   SNL_BOARD_MAX : default winning square (exact landing required)
//   POS_W / DIE_W : widths of a board square and a die face
//   state_e       : turn-sequencer FSM states
//   die_legal()   : true for faces 1..6
package snl_pkg;

    localparam int unsigned SNL_BOARD_MAX = 100;
    localparam int unsigned POS_W         = 7;
    localparam int unsigned DIE_W         = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRoll   = 3'd1,
        StMove   = 3'd2,
        StUpdate = 3'd3,
        StNext   = 3'd4,
        StDone   = 3'd5
    } state_e;

    function automatic logic die_legal(input logic [DIE_W-1:0] face);
        return (face != 3'd0) && (face != 3'd7);
    endfunction

endpackage

// File: rtl/snl_pos_bank.sv
// snl_pos_bank: per-player position register file.
//   clk_i       : clock, rising edge
//   reset_i     : synchronous active-high reset, clears every position
//   clr_i       : synchronous clear (new game)
//   we_i        : write enable; wpid_i selects player, wdata_i is the new square
//   rpid_i      : read index; rdata_o is that player's square
//   pos_flat_o  : all positions, player i at [POS_W*i +: POS_W]
module snl_pos_bank
    import snl_pkg::*;
#(
    parameter int unsigned N_PLAYERS = 4,
    parameter int unsigned PID_W     = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clr_i,
    input  logic                       we_i,
    input  logic [PID_W-1:0]           wpid_i,
    input  logic [POS_W-1:0]           wdata_i,
    input  logic [PID_W-1:0]           rpid_i,
    output logic [POS_W-1:0]           rdata_o,
    output logic [POS_W*N_PLAYERS-1:0] pos_flat_o
);

    logic [POS_W-1:0] pos_q [N_PLAYERS];

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            for (int i = 0; i < int'(N_PLAYERS); i++) pos_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                if (wpid_i == PID_W'(i)) pos_q[i] <= wdata_i;
            end
        end
    end

    // Compare-based decode keeps the index width independent of N_PLAYERS.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
            if (rpid_i == PID_W'(i)) rdata_o = pos_q[i];
        end
    end

    always_comb begin
        pos_flat_o = '0;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
            pos_flat_o[POS_W*i +: POS_W] = pos_q[i];
        end
    end

endmodule

// File: rtl/snl_turn_scheduler.sv
// snl_turn_scheduler: round-robin turn sequencer for N players sharing one dice
// unit and one move engine (snake/ladder resolver). Owns all positions and
// detects the winner.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   start_i                 : 1-cycle pulse, starts a game from idle or done
//   roll_req_o / roll_vld_i / roll_val_i : dice handshake (faces 0 and 7 dropped)
//   move_req_o, move_pid_o, move_from_o, move_roll_o : move-engine request
//   move_ack_i, move_to_i   : move-engine response (resolved square)
//   cur_player_o            : player whose turn it is
//   pos_flat_o              : all positions, player i at [7i+6:7i]
//   busy_o, win_o, winner_o : status
// Optional feature, macro SNL_EXTRA_TURN_ON_SIX_EN: a legal six grants another
// roll to the same player; the third consecutive six voids the move and ends
// the turn.
module snl_turn_scheduler
    import snl_pkg::*;
#(
    parameter int unsigned N_PLAYERS = 4,
    parameter int unsigned PID_W     = 3,
    parameter int unsigned BOARD_MAX = SNL_BOARD_MAX
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       roll_req_o,
    input  logic                       roll_vld_i,
    input  logic [DIE_W-1:0]           roll_val_i,
    output logic                       move_req_o,
    output logic [PID_W-1:0]           move_pid_o,
    output logic [POS_W-1:0]           move_from_o,
    output logic [DIE_W-1:0]           move_roll_o,
    input  logic                       move_ack_i,
    input  logic [POS_W-1:0]           move_to_i,
    output logic [PID_W-1:0]           cur_player_o,
    output logic [POS_W*N_PLAYERS-1:0] pos_flat_o,
    output logic                       busy_o,
    output logic                       win_o,
    output logic [PID_W-1:0]           winner_o
);

    localparam logic [POS_W:0]   BoardMax = (POS_W+1)'(BOARD_MAX);
    localparam logic [PID_W-1:0] LastPid  = PID_W'(N_PLAYERS - 1);

    state_e           state_q, state_d;
    logic [PID_W-1:0] cur_q, cur_d;
    logic [DIE_W-1:0] roll_q, roll_d;
    logic [POS_W-1:0] mto_q, mto_d;
    logic [POS_W-1:0] cur_pos;
    logic             pos_we, pos_clr;
    logic [POS_W:0]   roll_sum;
    logic             roll_fits, mto_ok;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
    logic [2:0]       six_q, six_d;
`endif

    snl_pos_bank #(
        .N_PLAYERS (N_PLAYERS),
        .PID_W     (PID_W)
    ) u_pos_bank (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (pos_clr),
        .we_i       (pos_we),
        .wpid_i     (cur_q),
        .wdata_i    (mto_q),
        .rpid_i     (cur_q),
        .rdata_o    (cur_pos),
        .pos_flat_o (pos_flat_o)
    );

    assign roll_sum  = {1'b0, cur_pos} + {{(POS_W + 1 - DIE_W){1'b0}}, roll_val_i};
    assign roll_fits = (roll_sum <= BoardMax);
    // A resolver answer of 0 or beyond the board is a protocol error: ignore it.
    assign mto_ok    = (mto_q != '0) && ({1'b0, mto_q} <= BoardMax);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        roll_d     = roll_q;
        mto_d      = mto_q;
        pos_we     = 1'b0;
        pos_clr    = 1'b0;
        roll_req_o = 1'b0;
        move_req_o = 1'b0;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
        six_d      = six_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRoll;
                    cur_d   = '0;
                    pos_clr = 1'b1;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
                    six_d   = '0;
`endif
                end
            end
            StRoll: begin
                roll_req_o = 1'b1;
                if (roll_vld_i && die_legal(roll_val_i)) begin
                    roll_d = roll_val_i;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
                    if (roll_val_i == 3'd6) begin
                        six_d = six_q + 3'd1;
                        if (six_q == 3'd2)  state_d = StNext;  // third six: void
                        else if (roll_fits) state_d = StMove;
                        else                state_d = StRoll;  // overshoot, roll again
                    end else begin
                        state_d = roll_fits ? StMove : StNext;
                    end
`else
                    state_d = roll_fits ? StMove : StNext;
`endif
                end
            end
            StMove: begin
                move_req_o = 1'b1;
                if (move_ack_i) begin
                    mto_d   = move_to_i;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                pos_we = mto_ok;
                if (mto_ok && ({1'b0, mto_q} == BoardMax)) begin
                    state_d = StDone;
                end else begin
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
                    state_d = (roll_q == 3'd6) ? StRoll : StNext;
`else
                    state_d = StNext;
`endif
                end
            end
            StNext: begin
                cur_d   = (cur_q == LastPid) ? '0 : cur_q + 1'b1;
                state_d = StRoll;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
                six_d   = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cur_q   <= '0;
            roll_q  <= '0;
            mto_q   <= '0;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
            six_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            roll_q  <= roll_d;
            mto_q   <= mto_d;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
            six_q   <= six_d;
`endif
        end
    end

    // Payload comes straight from registers, so it cannot change while in MOVE.
    assign move_pid_o   = cur_q;
    assign move_from_o  = cur_pos;
    assign move_roll_o  = roll_q;
    assign cur_player_o = cur_q;
    assign win_o        = (state_q == StDone);
    assign winner_o     = win_o ? cur_q : '0;
    assign busy_o       = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_snl_turn_scheduler.sv
// Directed bench for snl_turn_scheduler (N=4, PID_W=3, BOARD_MAX=100).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_snl_turn_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        roll_req;
    logic        roll_vld = 1'b0;
    logic [2:0]  roll_val = 3'd0;
    logic        move_req;
    logic [2:0]  move_pid;
    logic [6:0]  move_from;
    logic [2:0]  move_roll;
    logic        move_ack = 1'b0;
    logic [6:0]  move_to = 7'd0;
    logic [2:0]  cur_player;
    logic [27:0] pos_flat;
    logic        busy;
    logic        win;
    logic [2:0]  winner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snl_turn_scheduler #(
        .N_PLAYERS (4),
        .PID_W     (3),
        .BOARD_MAX (100)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .roll_req_o   (roll_req),
        .roll_vld_i   (roll_vld),
        .roll_val_i   (roll_val),
        .move_req_o   (move_req),
        .move_pid_o   (move_pid),
        .move_from_o  (move_from),
        .move_roll_o  (move_roll),
        .move_ack_i   (move_ack),
        .move_to_i    (move_to),
        .cur_player_o (cur_player),
        .pos_flat_o   (pos_flat),
        .busy_o       (busy),
        .win_o        (win),
        .winner_o     (winner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [6:0] pos_of(input int i);
        return pos_flat[7*i +: 7];
    endfunction

    task automatic roll_in(input logic [2:0] v);
        roll_vld = 1'b1;
        roll_val = v;
        step();
        roll_vld = 1'b0;
        roll_val = 3'd0;
    endtask

    task automatic ack_in(input logic [6:0] to);
        move_ack = 1'b1;
        move_to  = to;
        step();
        move_ack = 1'b0;
        move_to  = 7'd0;
    endtask

    // Ordinary single turn: roll, 0-wait ack, UPDATE, NEXT -> back in ROLL.
    task automatic plain_turn(input logic [2:0] v, input logic [6:0] to);
        roll_in(v);
        ack_in(to);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles.
        step();
        step();
        chk("rst_roll_req", 32'(roll_req), 32'd0);
        chk("rst_move_req", 32'(move_req), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur", 32'(cur_player), 32'd0);
        chk("rst_pos_flat", 32'(pos_flat), 32'd0);
        chk("rst_payload", 32'({move_pid, move_from, move_roll}), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_hold_busy", 32'(busy), 32'd0);

        // Start: roll_req one cycle later.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_roll_req", 32'(roll_req), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);

        // Four players each roll 3, engine returns from+3; 4-cycle turns.
        for (int p = 0; p < 4; p++) begin
            chk("rr_cur", 32'(cur_player), 32'(p));
            roll_in(3'd3);
            chk("rr_move_req", 32'(move_req), 32'd1);
            chk("rr_pid", 32'(move_pid), 32'(p));
            chk("rr_from", 32'(move_from), 32'd0);
            chk("rr_roll", 32'(move_roll), 32'd3);
            ack_in(7'd3);
            chk("rr_req_drop", 32'(move_req), 32'd0);
            step();
            step();
            chk("rr_back_in_roll", 32'(roll_req), 32'd1);
        end
        chk("rr_wrap_cur", 32'(cur_player), 32'd0);
        chk("rr_pos_flat", 32'(pos_flat), 32'({7'd3, 7'd3, 7'd3, 7'd3}));

        // P0 climbs a ladder to 97; others step to 4.
        plain_turn(3'd1, 7'd97);
        for (int p = 1; p < 4; p++) plain_turn(3'd1, 7'd4);
        chk("p0_at_97", 32'(pos_of(0)), 32'd97);
        chk("cur_back_0", 32'(cur_player), 32'd0);

        // Overshoot: 97 + 5 > 100, no move request, turn passes.
        roll_in(3'd5);
        chk("over_no_move", 32'(move_req), 32'd0);
        step();
        chk("over_cur", 32'(cur_player), 32'd1);
        chk("over_pos", 32'(pos_of(0)), 32'd97);
        for (int p = 1; p < 4; p++) plain_turn(3'd1, 7'd5);

        // Exact landing wins.
        roll_in(3'd3);
        chk("win_from", 32'(move_from), 32'd97);
        chk("win_roll", 32'(move_roll), 32'd3);
        ack_in(7'd100);
        step();
        chk("win_win", 32'(win), 32'd1);
        chk("win_winner", 32'(winner), 32'd0);
        chk("win_busy", 32'(busy), 32'd0);
        chk("win_pos", 32'(pos_of(0)), 32'd100);

        // Handshakes ignored in DONE.
        roll_vld = 1'b1;
        roll_val = 3'd2;
        move_ack = 1'b1;
        step();
        roll_vld = 1'b0;
        move_ack = 1'b0;
        chk("done_hold_win", 32'(win), 32'd1);
        chk("done_no_req", 32'({roll_req, move_req}), 32'd0);

        // Restart from DONE clears the board.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pos", 32'(pos_flat), 32'd0);
        chk("restart_win", 32'(win), 32'd0);
        chk("restart_cur", 32'(cur_player), 32'd0);

        // Illegal faces 0 and 7 dropped; 4 is used.
        roll_vld = 1'b1;
        roll_val = 3'd0;
        step();
        chk("bad0_roll_req", 32'(roll_req), 32'd1);
        chk("bad0_move_req", 32'(move_req), 32'd0);
        roll_val = 3'd7;
        step();
        chk("bad7_roll_req", 32'(roll_req), 32'd1);
        chk("bad7_move_req", 32'(move_req), 32'd0);
        roll_val = 3'd4;
        step();
        chk("good4_move_req", 32'(move_req), 32'd1);
        chk("good4_roll", 32'(move_roll), 32'd4);

        // Delayed ack: payload stable; stray roll_vld in MOVE ignored.
        roll_val = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_move_req", 32'(move_req), 32'd1);
            chk("wait_payload", 32'({move_pid, move_from, move_roll}), 32'({3'd0, 7'd0, 3'd4}));
        end
        roll_vld = 1'b0;
        roll_val = 3'd0;
        ack_in(7'd120);
        chk("bad_to_req_drop", 32'(move_req), 32'd0);
        step();
        chk("bad_to_pos", 32'(pos_of(0)), 32'd0);
        step();
        chk("bad_to_cur", 32'(cur_player), 32'd1);

`ifdef SNL_EXTRA_TURN_ON_SIX_EN
        // P1: 6, 6, 2 -> three moves by the same player.
        roll_in(3'd6);
        ack_in(7'd6);
        step();
        chk("six1_same_player", 32'({roll_req, cur_player}), 32'({1'b1, 3'd1}));
        roll_in(3'd6);
        ack_in(7'd12);
        step();
        chk("six2_same_player", 32'({roll_req, cur_player}), 32'({1'b1, 3'd1}));
        roll_in(3'd2);
        ack_in(7'd14);
        step();
        step();
        chk("six_end_cur", 32'(cur_player), 32'd2);
        chk("six_end_pos", 32'(pos_of(1)), 32'd14);
        // P2: 6, 6, 6 -> third voided.
        roll_in(3'd6);
        ack_in(7'd6);
        step();
        roll_in(3'd6);
        ack_in(7'd12);
        step();
        roll_in(3'd6);
        chk("six3_no_move", 32'(move_req), 32'd0);
        step();
        chk("six3_cur", 32'(cur_player), 32'd3);
        chk("six3_pos", 32'(pos_of(2)), 32'd12);
`else
        // Without the extra-turn feature a six ends the turn normally.
        roll_in(3'd6);
        chk("six_move_req", 32'(move_req), 32'd1);
        ack_in(7'd6);
        step();
        step();
        chk("six_cur", 32'(cur_player), 32'd2);
        chk("six_pos", 32'(pos_of(1)), 32'd6);
`endif

        // Reset mid-turn aborts everything.
        roll_in(3'd1);
        chk("pre_rst_move_req", 32'(move_req), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_req", 32'({roll_req, move_req}), 32'd0);
        chk("mid_rst_pos", 32'(pos_flat), 32'd0);
        chk("mid_rst_cur", 32'(cur_player), 32'd0);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
